i_type_decode_stage: RTL and testbench

Pipelined decode stage that accepts raw 32-bit instruction words and produces the operand controls consumed by the I-type computational block: sign-extended or shift-amount immediate, func3, srli_e, register indices and an illegal flag. It sits between fetch and the I-type ALU. It uses a two-entry (output register + skid) valid/ready buffer so that full throughput is kept under backpressure. It also counts accepted illegal instructions.

---
 rtl/i_type_decode_stage.sv | 139 +++++++++++++
 tb/tb_i_type_decode_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i_type_decode_stage.sv
// Decode stage for RV32 OP-IMM words: turns raw instructions into ALU operand
// controls behind a two-entry (output + skid) valid/ready buffer.
module i_type_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_func3,
    output logic        out_srli_e,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rd,
    output logic [31:0] out_pc,
    output logic        out_illegal,
    output logic [15:0] illegal_count
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  func3;
        logic        srli_e;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    entry_t      dec;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] illegal_count_q, illegal_count_d;
    logic        legal;
    logic        accept;
    logic        emit;

    // Decode of the word currently presented upstream.
    always_comb begin
        // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
        dec    = '0;
        dec.pc = in_pc;
        unique case (in_instr[14:12])
            3'b001:  legal = (in_instr[31:25] == F7_ZERO);
            3'b101:  legal = (in_instr[31:25] == F7_ZERO) || (in_instr[31:25] == F7_ALT);
            default: legal = 1'b1;
        endcase
        legal = legal && (in_instr[6:0] == OPC_OP_IMM);

        if (legal) begin
            dec.func3 = in_instr[14:12];
            dec.rs1   = in_instr[19:15];
            dec.rd    = in_instr[11:7];
            if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
                dec.imm = {27'b0, in_instr[24:20]};
            end else begin
                dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            dec.srli_e = (in_instr[14:12] == 3'b101) && !in_instr[30];
        end else begin
            // Illegal words go downstream as addi x0,x0,0 with the flag set.
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready && !flush;
    assign emit     = out_valid_q && out_ready;

    always_comb begin
        out_d           = out_q;
        skid_d          = skid_q;
        out_valid_d     = out_valid_q;
        skid_valid_d    = skid_valid_q;
        illegal_count_d = illegal_count_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || emit) begin
            // Output slot frees up: skid has priority so order stays FIFO.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        if (accept && dec.illegal && illegal_count_q != 16'hFFFF) begin
            illegal_count_d = illegal_count_q + 16'd1;
        end
    end

    // NOTE: the data registers are reset too, so out_* reads as zero after reset rather than stale X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q           <= '0;
            skid_q          <= '0;
            out_valid_q     <= 1'b0;
            skid_valid_q    <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            out_q           <= out_d;
            skid_q          <= skid_d;
            out_valid_q     <= out_valid_d;
            skid_valid_q    <= skid_valid_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_imm       = out_q.imm;
    assign out_func3     = out_q.func3;
    assign out_srli_e    = out_q.srli_e;
    assign out_rs1       = out_q.rs1;
    assign out_rd        = out_q.rd;
    assign out_pc        = out_q.pc;
    assign out_illegal   = out_q.illegal;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_i_type_decode_stage.sv
// Directed bench for i_type_decode_stage: decode vector table, then hand-written
// backpressure, flush, reset and counter-saturation sequences.
module tb_i_type_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_func3;
    logic        out_srli_e;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [15:0] illegal_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i_type_decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_imm       (out_imm),
        .out_func3     (out_func3),
        .out_srli_e    (out_srli_e),
        .out_rs1       (out_rs1),
        .out_rd        (out_rd),
        .out_pc        (out_pc),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  func3;
        logic        srli_e;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    localparam logic [31:0] ADDI_M1 = 32'hFFF08293;
    localparam logic [31:0] BAD_OP  = 32'h002081B3;

    initial begin
        vecs[0]  = '{32'hFFF08293, 32'hFFFFFFFF, 3'd0, 1'b0, 5'd1,  5'd5,  1'b0}; // addi x5,x1,-1
        vecs[1]  = '{32'h40715193, 32'h00000007, 3'd5, 1'b0, 5'd2,  5'd3,  1'b0}; // srai x3,x2,7
        vecs[2]  = '{32'h00715193, 32'h00000007, 3'd5, 1'b1, 5'd2,  5'd3,  1'b0}; // srli x3,x2,7
        vecs[3]  = '{32'h40111093, 32'h00000000, 3'd0, 1'b0, 5'd0,  5'd0,  1'b1}; // slli, bad func7
        vecs[4]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 5'd0,  5'd0,  1'b1}; // OP opcode
        vecs[5]  = '{32'h01F39313, 32'h0000001F, 3'd1, 1'b0, 5'd7,  5'd6,  1'b0}; // slli x6,x7,31
        vecs[6]  = '{32'h7FFFFF93, 32'h000007FF, 3'd7, 1'b0, 5'd31, 5'd31, 1'b0}; // andi x31,x31,2047
        vecs[7]  = '{32'h80012093, 32'hFFFFF800, 3'd2, 1'b0, 5'd2,  5'd1,  1'b0}; // slti x1,x2,-2048
        vecs[8]  = '{32'hC0715193, 32'h00000000, 3'd0, 1'b0, 5'd0,  5'd0,  1'b1}; // shift-right, func7 0x60
        vecs[9]  = '{32'hFFF14193, 32'hFFFFFFFF, 3'd4, 1'b0, 5'd2,  5'd3,  1'b0}; // xori x3,x2,-1
        vecs[10] = '{32'h00012083, 32'h00000000, 3'd0, 1'b0, 5'd0,  5'd0,  1'b1}; // lw opcode

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (3) step();
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_imm", out_imm, 32'd0);
        check("reset count", {16'b0, illegal_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Decode table, streamed back-to-back with out_ready=1.
        for (int i = 0; i < NVEC; i++) begin
            push(vecs[i].instr, 32'h1000 + 32'(i * 4));
            step();
            check($sformatf("vec%0d imm", i), out_imm, vecs[i].imm);
            check($sformatf("vec%0d ctl", i),
                  {16'b0, out_valid, out_func3, out_srli_e, out_rs1, out_rd, out_illegal},
                  {16'b0, 1'b1, vecs[i].func3, vecs[i].srli_e, vecs[i].rs1, vecs[i].rd, vecs[i].illegal});
            check($sformatf("vec%0d pc", i), out_pc, 32'h1000 + 32'(i * 4));
        end
        in_valid = 1'b0;
        step();
        check("table drain out_valid", {31'b0, out_valid}, 32'd0);
        check("table illegal_count", {16'b0, illegal_count}, 32'd4);

        // Backpressure: A to output, B to skid, C stalled upstream.
        out_ready = 1'b0;
        push(ADDI_M1, 32'hA0);
        step();
        push(ADDI_M1, 32'hB0);
        step();
        check("bp in_ready after B", {31'b0, in_ready}, 32'd0);
        push(ADDI_M1, 32'hC0);
        step();
        step();
        check("bp held pc", out_pc, 32'hA0);
        check("bp held valid", {31'b0, out_valid}, 32'd1);
        check("bp C stalled", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("bp drain 1 pc", out_pc, 32'hB0);
        check("bp in_ready rises", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp drain 2 pc", out_pc, 32'hC0);
        check("bp drain 2 valid", {31'b0, out_valid}, 32'd1);
        step();
        check("bp empty", {31'b0, out_valid}, 32'd0);
        check("bp count", {16'b0, illegal_count}, 32'd4);

        // Flush with both entries full and an illegal word presented.
        out_ready = 1'b0;
        push(ADDI_M1, 32'hD0);
        step();
        push(ADDI_M1, 32'hD4);
        step();
        push(BAD_OP, 32'hD8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush full out_valid", {31'b0, out_valid}, 32'd0);
        check("flush full in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        check("flush full word absent", {31'b0, out_valid}, 32'd0);

        // Flush while in_ready=1: the presented illegal word must not be counted.
        out_ready = 1'b0;
        push(ADDI_M1, 32'hE0);
        step();
        push(BAD_OP, 32'hE4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush single out_valid", {31'b0, out_valid}, 32'd0);
        check("flush count unchanged", {16'b0, illegal_count}, 32'd4);

        // Asynchronous reset mid-cycle with both entries full.
        push(ADDI_M1, 32'hF0);
        step();
        push(BAD_OP, 32'hF4);
        step();
        in_valid = 1'b0;
        check("pre-reset in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst in_ready", {31'b0, in_ready}, 32'd1);
        check("async rst count", {16'b0, illegal_count}, 32'd0);
        check("async rst out_pc", out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'h40715193, 32'h200);
        step();
        in_valid = 1'b0;
        check("post-reset imm", out_imm, 32'h7);
        check("post-reset ctl", {16'b0, out_valid, out_func3, out_srli_e, out_rs1, out_rd, out_illegal},
              {16'b0, 1'b1, 3'd5, 1'b0, 5'd2, 5'd3, 1'b0});

        // Saturation: stream illegal words until the counter reaches its limit.
        push(BAD_OP, 32'h300);
        repeat (65534) step();
        check("count before sat", {16'b0, illegal_count}, 32'h0000FFFE);
        step();
        check("count at sat", {16'b0, illegal_count}, 32'h0000FFFF);
        repeat (2) step();
        in_valid = 1'b0;
        check("count stays sat", {16'b0, illegal_count}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
